alu_control_unit: RTL and testbench



---
 rtl/alu_control_unit.sv | 150 +++++++++++++++
 tb/tb_alu_control_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute controller feeding an external combinational 8-bit ALU.
// Fetches 16-bit instructions over valid/ready, holds a 4x8 register file, writes results back.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_FETCH     | instr_ready high, wait for instr_valid, latch IR, advance PC
// S_DECODE    | ALU: load operands/select/rotate; LDI: stage imm; NOP/HALT
// S_EXECUTE   | ALU inputs stable, capture alu_out as the write-back result
// S_WRITEBACK | wb_valid pulse, register file written at end of cycle
// S_HALT      | terminal until reset, halted high
module alu_control_unit #(
  parameter int unsigned PC_W      = 8,
  parameter logic [7:0]  REG_RESET = 8'h00
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  output logic [7:0]      alu_in0,
  output logic [7:0]      alu_in1,
  output logic [3:0]      alu_select,
  output logic [1:0]      alu_rotate,
  input  logic [7:0]      alu_out,
  output logic            wb_valid,
  output logic [1:0]      wb_addr,
  output logic [7:0]      wb_data,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [15:0]     ir_q;
  logic [7:0]      regs_q [4];
  logic            ready_q;
  logic [7:0]      alu_in0_q;
  logic [7:0]      alu_in1_q;
  logic [3:0]      alu_select_q;
  logic [1:0]      alu_rotate_q;
  logic            wb_valid_q;
  logic [1:0]      wb_addr_q;
  logic [7:0]      wb_data_q;
  logic            halted_q;

  assign pc_d = pc_q + PC_W'(1);

  // wb_data_q doubles as the result register: EXECUTE captures alu_out, LDI stages imm
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= REG_RESET;
      ready_q      <= 1'b0;
      alu_in0_q    <= '0;
      alu_in1_q    <= '0;
      alu_select_q <= '0;
      alu_rotate_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      halted_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (ready_q && instr_valid) begin
            ir_q    <= instr;
            pc_q    <= pc_d;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          case (ir_q[15:14])
            OP_ALU: begin
              alu_in0_q    <= regs_q[ir_q[5:4]];
              alu_in1_q    <= regs_q[ir_q[3:2]];
              alu_select_q <= ir_q[13:10];
              alu_rotate_q <= ir_q[9:8];
              state_q      <= S_EXECUTE;
            end
            OP_LDI: begin
              wb_valid_q <= 1'b1;
              wb_addr_q  <= ir_q[13:12];
              wb_data_q  <= ir_q[7:0];
              state_q    <= S_WRITEBACK;
            end
            OP_NOP: begin
              ready_q <= 1'b1;
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_EXECUTE: begin
          wb_valid_q <= 1'b1;
          wb_addr_q  <= ir_q[7:6];
          wb_data_q  <= alu_out;
          state_q    <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          regs_q[wb_addr_q] <= wb_data_q;
          ready_q           <= 1'b1;
          state_q           <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign instr_addr  = pc_q;
  assign instr_ready = ready_q;
  assign alu_in0     = alu_in0_q;
  assign alu_in1     = alu_in1_q;
  assign alu_select  = alu_select_q;
  assign alu_rotate  = alu_rotate_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a small behavioural ALU on alu_out.
module tb_alu_control_unit;

  logic        clk;
  logic        reset_n;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_in0;
  logic [7:0]  alu_in1;
  logic [3:0]  alu_select;
  logic [1:0]  alu_rotate;
  logic [7:0]  alu_out;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        halted;

  int checks;
  int errors;

  alu_control_unit #(.PC_W(8), .REG_RESET(8'h00)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in0     (alu_in0),
    .alu_in1     (alu_in1),
    .alu_select  (alu_select),
    .alu_rotate  (alu_rotate),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass A; then rotate left
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s, input logic [1:0] r);
    logic [7:0] t;
    case (s)
      4'h0: t = a + b;
      4'h1: t = a - b;
      4'h2: t = a & b;
      4'h3: t = a | b;
      4'h4: t = a ^ b;
      default: t = a;
    endcase
    return (t << r) | (t >> (4'd8 - {2'b00, r}));
  endfunction

  assign alu_out = alu_model(alu_in0, alu_in1, alu_select, alu_rotate);

  // Presents one instruction and returns 1ns after its handshake edge (DECODE cycle).
  task automatic issue(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_timeout instr_ready=%b required 1", instr_ready);
    end
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", instr_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (instr_addr !== 8'h00) begin errors++; $display("FAIL rst_pc got=%h exp=00", instr_addr); end
    checks++; if ({alu_in0, alu_in1, alu_select, alu_rotate, wb_addr, wb_data} !== 32'h0) begin
      errors++; $display("FAIL rst_datapath got=%h exp=0", {alu_in0, alu_in1, alu_select, alu_rotate, wb_addr, wb_data});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got=%b exp=1", instr_ready); end
    checks++; if (instr_addr !== 8'h00) begin errors++; $display("FAIL fetch_pc0 got=%h exp=00", instr_addr); end
  endtask

  task automatic test_ldi();
    issue(16'h503C);
    checks++; if (instr_addr !== 8'h01) begin errors++; $display("FAIL ldi_pc1 got=%h exp=01", instr_addr); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL ldi_decode_ready got=%b exp=0", instr_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ldi_early_wb got=%b exp=0", wb_valid); end
    step();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ldi_wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_addr !== 2'd1) begin errors++; $display("FAIL ldi_wb_addr got=%0d exp=1", wb_addr); end
    checks++; if (wb_data !== 8'h3C) begin errors++; $display("FAIL ldi_wb_data got=%h exp=3c", wb_data); end
    step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ldi_wb_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_alu();
    issue(16'h4005);
    issue(16'h5007);
    issue(16'h0984);
    step();
    checks++; if (alu_in0 !== 8'h05) begin errors++; $display("FAIL alu_in0 got=%h exp=05", alu_in0); end
    checks++; if (alu_in1 !== 8'h07) begin errors++; $display("FAIL alu_in1 got=%h exp=07", alu_in1); end
    checks++; if (alu_select !== 4'h2) begin errors++; $display("FAIL alu_select got=%h exp=2", alu_select); end
    checks++; if (alu_rotate !== 2'd1) begin errors++; $display("FAIL alu_rotate got=%0d exp=1", alu_rotate); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_exec_wb got=%b exp=0", wb_valid); end
    step();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_addr !== 2'd2) begin errors++; $display("FAIL alu_wb_addr got=%0d exp=2", wb_addr); end
    checks++; if (wb_data !== 8'h0A) begin errors++; $display("FAIL alu_wb_data got=%h exp=0a", wb_data); end
    step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready cyc=%0d got=%b exp=1", i, instr_ready); end
      checks++; if (instr_addr !== 8'h04) begin errors++; $display("FAIL idle_pc cyc=%0d got=%h exp=04", i, instr_addr); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle_wb cyc=%0d got=%b exp=0", i, wb_valid); end
    end
  endtask

  task automatic test_same_reg();
    issue(16'h40FF);
    issue(16'h0000);
    step();
    checks++; if ({alu_in0, alu_in1} !== 16'hFFFF) begin errors++; $display("FAIL same_ops got=%h exp=ffff", {alu_in0, alu_in1}); end
    step();
    checks++; if ({wb_valid, wb_addr, wb_data} !== 11'b1_00_11111110) begin
      errors++; $display("FAIL same_wb got=%b/%0d/%h exp=1/0/fe", wb_valid, wb_addr, wb_data);
    end
    issue(16'h0CC0);
    step();
    checks++; if (alu_in0 !== 8'hFE) begin errors++; $display("FAIL raw_r0 got=%h exp=fe", alu_in0); end
    step();
    checks++; if ({wb_valid, wb_addr, wb_data} !== 11'b1_11_11111110) begin
      errors++; $display("FAIL raw_wb got=%b/%0d/%h exp=1/3/fe", wb_valid, wb_addr, wb_data);
    end
  endtask

  task automatic test_pc_wrap_halt();
    do_reset();
    for (int i = 0; i < 255; i++) issue(16'h8000);
    @(negedge clk);
    checks++; if (instr_addr !== 8'hFF) begin errors++; $display("FAIL pc_255 got=%h exp=ff", instr_addr); end
    issue(16'h8000);
    checks++; if (instr_addr !== 8'h00) begin errors++; $display("FAIL pc_wrap got=%h exp=00", instr_addr); end
    issue(16'hC000);
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({halted, instr_ready, wb_valid} !== 3'b100) begin
        errors++; $display("FAIL halt cyc=%0d got halted/ready/wb=%b exp=100", i, {halted, instr_ready, wb_valid});
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    issue(16'h6011);
    issue(16'h0068);
    step();
    checks++; if (alu_in0 !== 8'h11) begin errors++; $display("FAIL mid_exec_op got=%h exp=11", alu_in0); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({alu_in0, alu_in1, alu_select, alu_rotate, wb_valid, wb_addr, wb_data, instr_ready, halted, instr_addr} !== 43'h0) begin
      errors++; $display("FAIL async_rst outputs not zero in0=%h in1=%h wbv=%b rdy=%b pc=%h", alu_in0, alu_in1, wb_valid, instr_ready, instr_addr);
    end
    repeat (2) begin
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_no_wb got=%b exp=0", wb_valid); end
    end
    reset_n = 1'b1;
    step();
    checks++; if ({instr_ready, instr_addr} !== 9'h100) begin errors++; $display("FAIL post_rst_fetch got=%b/%h exp=1/00", instr_ready, instr_addr); end
    issue(16'h4080);
    issue(16'h0CC8);
    step();
    checks++; if ({alu_in0, alu_in1} !== 16'h8000) begin errors++; $display("FAIL post_rst_regs got=%h exp=8000", {alu_in0, alu_in1}); end
    step();
    checks++; if ({wb_valid, wb_addr, wb_data} !== 11'b1_11_10000000) begin
      errors++; $display("FAIL post_rst_wb got=%b/%0d/%h exp=1/3/80", wb_valid, wb_addr, wb_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ldi();
    test_alu();
    test_idle();
    test_same_reg();
    test_pc_wrap_halt();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
